// File: rtl/gate_stim_checker.sv
// gate_stim_checker: steps {a,b} through 00,01,10,11, lets each vector settle,
// then checks six gate results and reports per-vector failures.
module gate_stim_checker #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       y_not,
   input  logic       y_and,
   input  logic       y_or,
   input  logic       y_xor,
   input  logic       y_nor,
   input  logic       y_nand,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask
);
   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
   localparam logic [3:0] LOAD = 4'(SETTLE - 1);
   state_t     state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] err_q, err_d;
   logic [3:0] fm_q, fm_d;
   logic       mism;
   assign a         = vec_q[1];
   assign b         = vec_q[0];
   assign busy      = (state_q == DRIVE) || (state_q == CHECK);
   assign done      = state_q == DONE;
   assign pass      = done && (err_q == 3'd0);
   assign err_count = err_q;
   assign fail_mask = fm_q;
   assign mism = (y_not != ~a) || (y_and != (a & b)) || (y_or != (a | b)) ||
                 (y_xor != (a ^ b)) || (y_nor != ~(a | b)) || (y_nand != ~(a & b));
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fm_d    = fm_q;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = DRIVE;
            vec_d   = 2'd0;
            cnt_d   = LOAD;
            err_d   = 3'd0;
            fm_d    = 4'd0;
         end
         DRIVE: begin
            if (cnt_q == 4'd0) state_d = CHECK;
            else cnt_d = cnt_q - 4'd1;
         end
         CHECK: begin
            if (mism) begin
               err_d = (err_q == 3'd4) ? err_q : err_q + 3'd1;
               fm_d  = fm_q | (4'b0001 << vec_q);
            end
            if (vec_q == 2'd3) state_d = DONE;
            else begin
               vec_d   = vec_q + 2'd1;
               cnt_d   = LOAD;
               state_d = DRIVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= 2'd0;
         cnt_q   <= 4'd0;
         err_q   <= 3'd0;
         fm_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fm_q    <= fm_d;
      end
   end
endmodule

// File: tb/tb_gate_stim_checker.sv
// tb_gate_stim_checker: scoreboard bench with a faultable gate stage and
// a per-vector reference model of the expected run results.
module tb_gate_stim_checker;
   typedef struct {
      int         t;
      logic [2:0] err;
      logic [3:0] fm;
      logic       ps;
   } exp_t;

   logic clk = 0, rst_n = 1, start = 0, st1 = 0, st15 = 0;
   logic a, b, busy, done, pass;
   logic [2:0] err_count;
   logic [3:0] fail_mask;
   logic [5:0] ys, junk = 0;
   logic [5:0] xm [4];
   logic stuck_and = 0, inv_not = 0, noise = 0;
   logic a1, b1, busy1, done1, pass1, a15, b15, busy15, done15, pass15;
   logic [2:0] err1, err15;
   logic [3:0] fm1, fm15;
   logic [5:0] ys1, ys15;
   int checks = 0, errors = 0, cyc = 0;
   exp_t sb[$];
   exp_t e;
   logic done_d = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Gate truth table ordered {not,and,or,xor,nor,nand}.
   function automatic logic [5:0] ideal(input logic [1:0] v);
      logic x, z;
      x = v[1];
      z = v[0];
      return {~x, x & z, x | z, x ^ z, ~(x | z), ~(x & z)};
   endfunction

   function automatic logic [5:0] faulty(input logic [1:0] v);
      logic [5:0] r;
      r = ideal(v) ^ xm[v];
      if (stuck_and) r[4] = 1'b0;
      if (inv_not) r[5] = v[1];
      return r;
   endfunction

   always_comb ys = noise ? junk : faulty({a, b});
   assign ys1  = ideal({a1, b1});
   assign ys15 = ideal({a15, b15});

   gate_stim_checker #(.SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .y_not(ys[5]), .y_and(ys[4]), .y_or(ys[3]), .y_xor(ys[2]), .y_nor(ys[1]), .y_nand(ys[0]),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_mask(fail_mask));
   gate_stim_checker #(.SETTLE(1)) d1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
      .y_not(ys1[5]), .y_and(ys1[4]), .y_or(ys1[3]), .y_xor(ys1[2]), .y_nor(ys1[1]), .y_nand(ys1[0]),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(fm1));
   gate_stim_checker #(.SETTLE(15)) d15 (
      .clk(clk), .rst_n(rst_n), .start(st15), .a(a15), .b(b15),
      .y_not(ys15[5]), .y_and(ys15[4]), .y_or(ys15[3]), .y_xor(ys15[2]), .y_nor(ys15[1]), .y_nand(ys15[0]),
      .busy(busy15), .done(done15), .pass(pass15), .err_count(err15), .fail_mask(fm15));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A vector fails iff the gate stage deviates from the truth table for it.
   function automatic exp_t model(input int entry);
      exp_t r;
      r.fm = 4'd0;
      r.err = 3'd0;
      for (int k = 0; k < 4; k++)
         if (faulty(2'(k)) != ideal(2'(k))) begin
            r.fm[k] = 1'b1;
            r.err++;
         end
      r.ps = (r.err == 0);
      r.t  = entry + 4 * (2 + 1);
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done && !done_d) begin
         if (sb.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk("done_latency", cyc, e.t);
            chk("err_count", err_count, e.err);
            chk("fail_mask", fail_mask, e.fm);
            chk("pass", pass, e.ps);
         end
      end else if (sb.size() > 0 && cyc > sb[0].t + 4) begin
         chk("done_timeout", 0, 1);
         void'(sb.pop_front());
      end
      done_d = done;
   end

   task automatic go();
      start = 1;
      @(posedge clk);
      #1 start = 0;
      sb.push_back(model(cyc));
   endtask

   task automatic wait_done();
      for (int n = 0; n < 100 && !done; n++) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_faults();
      stuck_and = 0;
      inv_not = 0;
      for (int k = 0; k < 4; k++) xm[k] = 6'd0;
   endtask

   task automatic latency(input int which, input int want);
      int n;
      n = 0;
      if (which == 1) st1 = 1; else st15 = 1;
      @(posedge clk);
      #1 st1 = 0;
      st15 = 0;
      while (!(which == 1 ? done1 : done15) && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      chk(which == 1 ? "latency_settle1" : "latency_settle15", n, want);
      chk("pass_long_short", which == 1 ? pass1 : pass15, 1);
   endtask

   initial begin
      clear_faults();
      #1 rst_n = 0;
      #2;
      chk("rst_outputs", {a, b, busy, done, pass, err_count, fail_mask}, 0);
      #20 rst_n = 1;
      repeat (2) @(posedge clk);
      #1 chk("idle_after_rst", {busy, done}, 0);

      // Clean stage: stimulus order and hold time.
      go();
      for (int i = 0; i < 12; i++) begin
         chk("vec_seq", {a, b}, i / 3);
         chk("busy_run", busy, 1);
         chk("pass_low_run", pass, 0);
         @(posedge clk);
         #1;
      end
      chk("done_hold", {done, pass, a, b}, 4'b1111);

      stuck_and = 1;
      go();
      wait_done();
      clear_faults();

      inv_not = 1;
      go();
      wait_done();
      clear_faults();

      xm[1] = 6'b000101;
      go();
      repeat (6) @(posedge clk);
      #1 chk("double_mis_once", {err_count, fail_mask}, {3'd1, 4'b0010});
      wait_done();

      // Start held through a whole run, then re-entry from DONE.
      clear_faults();
      xm[2] = 6'b001000;
      start = 1;
      @(posedge clk);
      #1 sb.push_back(model(cyc));
      for (int i = 0; i < 12; i++) begin
         chk("no_restart_vec", {a, b}, i / 3);
         chk("no_restart_busy", busy, 1);
         @(posedge clk);
         #1;
      end
      chk("held_done", done, 1);
      sb.push_back(model(cyc + 1));
      @(posedge clk);
      #1 chk("reentry", {busy, done, err_count, fail_mask, a, b}, {2'b10, 7'd0, 2'b00});
      start = 0;
      wait_done();
      repeat (2) @(posedge clk);
      #1 chk("stay_done", {done, a, b}, 3'b111);

      // Asynchronous reset during vector 10 CHECK.
      clear_faults();
      xm[0] = 6'b100000;
      go();
      repeat (8) @(posedge clk);
      #2 chk("pre_rst_state", {a, b, busy, err_count}, {3'b101, 3'd1});
      #1 rst_n = 0;
      sb.delete();
      #1 chk("async_rst", {a, b, busy, done, pass, err_count, fail_mask}, 0);
      #10 rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 chk("idle_until_start", {busy, done, a, b, err_count}, 0);
      end

      // Random faults with garbage on the gate inputs outside CHECK.
      clear_faults();
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 4; k++) xm[k] = $urandom_range(0, 1) ? 6'($urandom) : 6'd0;
         go();
         for (int i = 0; i < 12; i++) begin
            noise = (i % 3) < 2;
            junk = 6'($urandom);
            @(posedge clk);
            #1;
         end
         noise = 0;
         wait_done();
      end
      clear_faults();

      latency(1, 8);
      latency(15, 64);
      repeat (3) @(posedge clk);
      if (sb.size() != 0) chk("sb_leftover", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
